local_mem_bank_arbiter: RTL and testbench
=========================================

# local_mem_bank_arbiter

Two-master Avalon-MM arbiter that shares one 512-bit local-memory bank (EMIF side) between the host DMA master (m0) and the kernel global-memory master (m1). It sits in the board interconnect ahead of each bank's clock-crossing bridge, one instance per bank (4 banks). Write bursts are locked to their owner until the last beat. Read-response beats are steered back to the issuing master via an ownership FIFO.

## Interface
Parameters:
- DATA_WIDTH, 512, data bus width (bits)
- ADDR_WIDTH, 32, byte address width (26 word bits + 6 byte-offset bits)
- BURSTCOUNT_WIDTH, 5, burstcount width; max burst 16
- BYTEENABLE_WIDTH, 64, DATA_WIDTH/8
- RSP_FIFO_DEPTH, 16, outstanding read bursts tracked; power of two

Ports:
- clk  in  1  bank-side clock; all logic on rising edge
- reset_n  in  1  asynchronous assert, active-low reset
- mN_address  in  ADDR_WIDTH  master N (N=0,1) byte address
- mN_read / mN_write  in  1  master N command strobes (never both high)
- mN_burstcount  in  BURSTCOUNT_WIDTH  beats, 1..16
- mN_writedata  in  DATA_WIDTH  write beat
- mN_byteenable  in  BYTEENABLE_WIDTH  byte enables
- mN_waitrequest  out  1  command/beat not accepted
- mN_readdata  out  DATA_WIDTH  routed read data
- mN_readdatavalid  out  1  beat valid for master N
- s_address, s_read, s_write, s_burstcount, s_writedata, s_byteenable  out  as above  bank command
- s_waitrequest  in  1  bank backpressure
- s_readdata  in  DATA_WIDTH, s_readdatavalid  in  1  bank response
- err_unexpected_rsp  out  1  sticky: readdatavalid with empty ownership FIFO

## Operation
- States: IDLE, WBURST.
- IDLE: requesters are masters with read or write high. A read request is eligible only if the ownership FIFO is not full. Pick among eligible requesters by round-robin pointer rr (rr=0 favours m0). The winner's command is forwarded combinationally to s_*. Winner's mN_waitrequest = s_waitrequest. Loser waitrequest = 1.
- On acceptance (winner strobe & !s_waitrequest):
  - rr points to the other master.
  - Read: push {owner, burstcount} into FIFO.
  - Write with burstcount>1: go to WBURST, lock owner, beats_left = burstcount-1.
- WBURST: only the owner's write passes. The other master sees waitrequest=1. beats_left decrements per accepted beat. When the last beat is accepted, go to IDLE.
- Response routing: on s_readdatavalid, the beat goes to the owner at the FIFO head. A per-head beat counter increments. On beat == burstcount, pop the FIFO and clear the counter. Both mN_readdata are driven with s_readdata. Only the owner's readdatavalid is asserted.
- Simultaneous push and pop are both performed; occupancy is unchanged.
- FIFO full: reads stall and writes still arbitrate. FIFO empty with s_readdatavalid: drop the beat and set err_unexpected_rsp until reset.
- burstcount=0 is illegal input; it is treated as 1.

## Timing
- Command path: zero cycles, combinational from mN_* / s_waitrequest to s_* / mN_waitrequest.
- Response path: zero cycles, combinational from s_readdatavalid to mN_readdatavalid.
- State, rr, FIFO, counters and err update on the clk edge.
- Reset (reset_n low, asynchronous):
  - State = IDLE, rr = 0, FIFO empty, counters = 0, err_unexpected_rsp = 0.
  - s_read = s_write = 0, mN_readdatavalid = 0, mN_waitrequest = 1.
- Reset mid-burst or with reads outstanding discards all state. The surrounding reset domain also resets the EMIF, so no stale responses arrive.
- Back-to-back grants are allowed with no idle cycle between bursts from different masters.

## Configuration
- LOCAL_MEM_ARB_DMA_PRIORITY_EN defined: fixed priority. m0 (DMA) wins every IDLE arbitration when eligible, and rr is ignored.
- Not defined: round-robin as described above.
- Write-burst locking and response routing are identical in both modes.

## Test plan
- Both masters issue single reads continuously, s_waitrequest=0 -> grants alternate m0,m1,m0,…; each response beat appears only on the issuer's readdatavalid (round-robin build).
- m0 write burst 4 starts, m1 write requests in cycle 2 -> m1 waitrequest=1 until m0's 4th beat is accepted; m1 is granted next cycle.
- 16 outstanding reads of burstcount 2 with no responses, then one more read -> read stalls (waitrequest=1), a concurrent write is still accepted; the stall releases after the first 2 response beats pop.
- s_readdatavalid pulsed with FIFO empty -> no mN_readdatavalid; err_unexpected_rsp=1 and stays high until reset_n low.
- reset_n asserted mid write burst (beat 2 of 8) with 3 reads outstanding -> s_write=0 immediately, all waitrequest=1. After release, a fresh single read from m1 is granted and its response routes to m1.
- Fixed-priority build, both request continuously -> m0 granted every cycle, m1 starved until m0 deasserts.

Source files
------------

// File: rtl/local_mem_bank_arbiter_if.sv
// Avalon-MM burst bus bundle for one side of local_mem_bank_arbiter.
// The master modport drives commands; the slave modport returns wait/response.
interface local_mem_bank_arbiter_if #(
  parameter int DATA_WIDTH       = 512,
  parameter int ADDR_WIDTH       = 32,
  parameter int BURSTCOUNT_WIDTH = 5,
  parameter int BYTEENABLE_WIDTH = 64
);
  logic [ADDR_WIDTH-1:0]       address;
  logic                        read;
  logic                        write;
  logic [BURSTCOUNT_WIDTH-1:0] burstcount;
  logic [DATA_WIDTH-1:0]       writedata;
  logic [BYTEENABLE_WIDTH-1:0] byteenable;
  logic                        waitrequest;
  logic [DATA_WIDTH-1:0]       readdata;
  logic                        readdatavalid;

  modport master (
    output address, read, write, burstcount, writedata, byteenable,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, burstcount, writedata, byteenable,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/local_mem_bank_arbiter.sv
// Two-master Avalon-MM arbiter for one local-memory bank, with write-burst locking
// and read-response steering. Define LOCAL_MEM_ARB_DMA_PRIORITY_EN for fixed m0 priority.
module local_mem_bank_arbiter #(
  parameter int DATA_WIDTH       = 512,
  parameter int ADDR_WIDTH       = 32,
  parameter int BURSTCOUNT_WIDTH = 5,
  parameter int BYTEENABLE_WIDTH = 64,
  parameter int RSP_FIFO_DEPTH   = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  local_mem_bank_arbiter_if.slave  m0,
  local_mem_bank_arbiter_if.slave  m1,
  local_mem_bank_arbiter_if.master s,
  output logic                     err_unexpected_rsp
);

  localparam int PTR_W = $clog2(RSP_FIFO_DEPTH);
  localparam logic [PTR_W:0] FIFO_FULL_CNT = (PTR_W+1)'(RSP_FIFO_DEPTH);
  localparam logic [BURSTCOUNT_WIDTH-1:0] BC_ONE = BURSTCOUNT_WIDTH'(1);

  typedef enum logic {IDLE, WBURST} state_t;

  state_t                      state;
  logic                        owner;
  logic [BURSTCOUNT_WIDTH-1:0] beats_left;
`ifndef LOCAL_MEM_ARB_DMA_PRIORITY_EN
  logic                        rr;
`endif

  logic                        elig0, elig1;
  logic                        sel, gnt_valid, accept, push, pop;
  logic [ADDR_WIDTH-1:0]       sel_addr;
  logic                        sel_read, sel_write;
  logic [BURSTCOUNT_WIDTH-1:0] sel_bc, bc_eff;
  logic [DATA_WIDTH-1:0]       sel_wdata;
  logic [BYTEENABLE_WIDTH-1:0] sel_be;

  logic                        fifo_owner [RSP_FIFO_DEPTH];
  logic [BURSTCOUNT_WIDTH-1:0] fifo_bc    [RSP_FIFO_DEPTH];
  logic [PTR_W-1:0]            wr_ptr, rd_ptr;
  logic [PTR_W:0]              fifo_count;
  logic                        fifo_full, fifo_empty;
  logic                        head_owner;
  logic [BURSTCOUNT_WIDTH-1:0] head_bc, beat_cnt;
  logic                        rsp_valid, rsp_last;

  assign fifo_full  = (fifo_count == FIFO_FULL_CNT);
  assign fifo_empty = (fifo_count == '0);
  assign head_owner = fifo_owner[rd_ptr];
  assign head_bc    = fifo_bc[rd_ptr];

  // Arbitration: a read needs a free ownership slot; writes are always eligible.
  always_comb begin
    elig0     = m0.write | (m0.read & ~fifo_full);
    elig1     = m1.write | (m1.read & ~fifo_full);
    sel       = 1'b0;
    gnt_valid = 1'b0;
    if (state == WBURST) begin
      sel       = owner;
      gnt_valid = owner ? m1.write : m0.write;
    end else begin
`ifdef LOCAL_MEM_ARB_DMA_PRIORITY_EN
      if (elig0) begin
        sel       = 1'b0;
        gnt_valid = 1'b1;
      end else if (elig1) begin
        sel       = 1'b1;
        gnt_valid = 1'b1;
      end
`else
      if (elig0 && elig1) begin
        sel       = rr;
        gnt_valid = 1'b1;
      end else if (elig0) begin
        sel       = 1'b0;
        gnt_valid = 1'b1;
      end else if (elig1) begin
        sel       = 1'b1;
        gnt_valid = 1'b1;
      end
`endif
    end
    if (!reset_n) gnt_valid = 1'b0;
  end

  always_comb begin
    sel_addr  = sel ? m1.address    : m0.address;
    sel_read  = sel ? m1.read       : m0.read;
    sel_write = sel ? m1.write      : m0.write;
    sel_bc    = sel ? m1.burstcount : m0.burstcount;
    sel_wdata = sel ? m1.writedata  : m0.writedata;
    sel_be    = sel ? m1.byteenable : m0.byteenable;
    bc_eff    = (sel_bc == '0) ? BC_ONE : sel_bc;

    s.address    = sel_addr;
    s.read       = gnt_valid & sel_read & (state == IDLE);
    s.write      = gnt_valid & sel_write;
    s.burstcount = bc_eff;
    s.writedata  = sel_wdata;
    s.byteenable = sel_be;

    m0.waitrequest = (gnt_valid && !sel) ? s.waitrequest : 1'b1;
    m1.waitrequest = (gnt_valid &&  sel) ? s.waitrequest : 1'b1;

    accept = gnt_valid & ~s.waitrequest;
    push   = accept & sel_read & (state == IDLE);
  end

  // Response steering: head-of-FIFO owner receives each beat until its burst completes.
  always_comb begin
    rsp_valid = s.readdatavalid & ~fifo_empty & reset_n;
    rsp_last  = ((beat_cnt + BC_ONE) == head_bc);
    pop       = rsp_valid & rsp_last;

    m0.readdata      = s.readdata;
    m1.readdata      = s.readdata;
    m0.readdatavalid = rsp_valid & ~head_owner;
    m1.readdatavalid = rsp_valid &  head_owner;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_owner[wr_ptr] <= sel;
      fifo_bc[wr_ptr]    <= bc_eff;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state              <= IDLE;
      owner              <= 1'b0;
      beats_left         <= '0;
`ifndef LOCAL_MEM_ARB_DMA_PRIORITY_EN
      rr                 <= 1'b0;
`endif
      wr_ptr             <= '0;
      rd_ptr             <= '0;
      fifo_count         <= '0;
      beat_cnt           <= '0;
      err_unexpected_rsp <= 1'b0;
    end else begin
      if (accept) begin
        if (state == IDLE) begin
`ifndef LOCAL_MEM_ARB_DMA_PRIORITY_EN
          rr <= ~sel;
`endif
          if (sel_write && bc_eff != BC_ONE) begin
            state      <= WBURST;
            owner      <= sel;
            beats_left <= bc_eff - BC_ONE;
          end
        end else begin
          beats_left <= beats_left - BC_ONE;
          if (beats_left == BC_ONE) state <= IDLE;
        end
      end

      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase

      if (rsp_valid) beat_cnt <= pop ? '0 : beat_cnt + BC_ONE;
      if (s.readdatavalid && fifo_empty) err_unexpected_rsp <= 1'b1;
    end
  end

endmodule

// File: tb/tb_local_mem_bank_arbiter.sv
// Scoreboard bench for local_mem_bank_arbiter: expected grants and response beats
// are queued by the stimulus and checked by a negedge monitor.
module tb_local_mem_bank_arbiter;

  logic clk = 1'b0;
  logic reset_n;
  logic err;

  always #5 clk = ~clk;

  local_mem_bank_arbiter_if m0_if();
  local_mem_bank_arbiter_if m1_if();
  local_mem_bank_arbiter_if s_if();

  local_mem_bank_arbiter #(
    .DATA_WIDTH(512), .ADDR_WIDTH(32), .BURSTCOUNT_WIDTH(5),
    .BYTEENABLE_WIDTH(64), .RSP_FIFO_DEPTH(16)
  ) dut (
    .clk(clk), .reset_n(reset_n), .m0(m0_if), .m1(m1_if), .s(s_if),
    .err_unexpected_rsp(err)
  );

  typedef struct { int m; bit wr; logic [31:0] addr; } gnt_t;
  typedef struct { int m; logic [31:0] data; } rsp_t;

  gnt_t exp_gnt[$];
  rsp_t exp_rsp[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, got, exp);
    end
  endtask

  // Monitor: every accepted command and every routed response beat must match the queues.
  gnt_t g;
  rsp_t r;
  int   got_m;
  always @(negedge clk) begin
    if ((s_if.read || s_if.write) && !s_if.waitrequest) begin
      got_m = (!m0_if.waitrequest && m1_if.waitrequest) ? 0 :
              (m0_if.waitrequest && !m1_if.waitrequest) ? 1 : 2;
      checks++;
      if (exp_gnt.size() == 0) begin
        errors++;
        $display("FAIL grant_unexpected: got m%0d wr=%0d addr %h, required none",
                 got_m, s_if.write, s_if.address);
      end else begin
        g = exp_gnt.pop_front();
        if (got_m != g.m || s_if.write != g.wr || s_if.address != g.addr) begin
          errors++;
          $display("FAIL grant: got m%0d wr=%0d addr %h, required m%0d wr=%0d addr %h",
                   got_m, s_if.write, s_if.address, g.m, g.wr, g.addr);
        end
      end
    end
    if (m0_if.readdatavalid || m1_if.readdatavalid) begin
      got_m = (m0_if.readdatavalid && m1_if.readdatavalid) ? 2 : (m1_if.readdatavalid ? 1 : 0);
      checks++;
      if (exp_rsp.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected: got beat on m%0d data %h, required none",
                 got_m, s_if.readdata[31:0]);
      end else begin
        r = exp_rsp.pop_front();
        if (got_m != r.m ||
            (got_m == 1 ? m1_if.readdata[31:0] : m0_if.readdata[31:0]) != r.data) begin
          errors++;
          $display("FAIL rsp: got m%0d data %h, required m%0d data %h",
                   got_m, (got_m == 1 ? m1_if.readdata[31:0] : m0_if.readdata[31:0]),
                   r.m, r.data);
        end
      end
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic idle_all();
    m0_if.read = 0; m0_if.write = 0; m0_if.burstcount = 5'd1; m0_if.address = '0;
    m0_if.writedata = '0; m0_if.byteenable = '1;
    m1_if.read = 0; m1_if.write = 0; m1_if.burstcount = 5'd1; m1_if.address = '0;
    m1_if.writedata = '0; m1_if.byteenable = '1;
    s_if.waitrequest = 0; s_if.readdatavalid = 0; s_if.readdata = '0;
  endtask

  task automatic rsp_beat(input int m, input logic [31:0] d);
    s_if.readdatavalid = 1;
    s_if.readdata = {480'd0, d};
    if (m >= 0) exp_rsp.push_back('{m: m, data: d});
    settle();
    next();
    s_if.readdatavalid = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int rd_owner[$];
    int n0, n1, w, exp_rr;
    logic [31:0] a;

    // Reset state, with a request held during reset
    idle_all();
    reset_n = 0;
    m0_if.read = 1;
    repeat (2) @(posedge clk);
    settle();
    chk("rst_s_read", s_if.read, 0);
    chk("rst_s_write", s_if.write, 0);
    chk("rst_m0_wait", m0_if.waitrequest, 1);
    chk("rst_m1_wait", m1_if.waitrequest, 1);
    chk("rst_rdv", {m0_if.readdatavalid, m1_if.readdatavalid}, 0);
    chk("rst_err", err, 0);
    next();
    m0_if.read = 0;
    reset_n = 1;
    next();

    // Both masters read continuously: alternate (round-robin) or m0 only (priority)
    exp_rr = 0; n0 = 0; n1 = 0;
    for (int k = 0; k < 6; k++) begin
      m0_if.read = 1; m0_if.address = 32'h1000 + n0 * 64;
      m1_if.read = 1; m1_if.address = 32'h2000 + n1 * 64;
`ifdef LOCAL_MEM_ARB_DMA_PRIORITY_EN
      w = 0;
`else
      w = exp_rr;
`endif
      a = (w == 0) ? m0_if.address : m1_if.address;
      exp_gnt.push_back('{m: w, wr: 1'b0, addr: a});
      rd_owner.push_back(w);
      if (w == 0) n0++; else n1++;
      exp_rr = (w == 0) ? 1 : 0;
      settle();
      next();
    end
    m0_if.read = 0;
    m1_if.address = 32'h2000 + n1 * 64;
    exp_gnt.push_back('{m: 1, wr: 1'b0, addr: m1_if.address});
    rd_owner.push_back(1);
    settle();
    next();
    m1_if.read = 0;
    for (int i = 0; i < rd_owner.size(); i++) rsp_beat(rd_owner[i], 32'hD000_0000 + i);

    // m0 write burst of 4 locks out m1 (one bank stall in the middle)
    m0_if.write = 1; m0_if.burstcount = 5'd4; m0_if.address = 32'h3000;
    exp_gnt.push_back('{m: 0, wr: 1'b1, addr: 32'h3000});
    settle();
    next();
    m1_if.write = 1; m1_if.burstcount = 5'd1; m1_if.address = 32'h4000;
    exp_gnt.push_back('{m: 0, wr: 1'b1, addr: 32'h3000});
    settle();
    chk("wb_m1_wait_b2", m1_if.waitrequest, 1);
    next();
    s_if.waitrequest = 1;
    settle();
    chk("wb_m1_wait_stall", m1_if.waitrequest, 1);
    chk("wb_m0_wait_stall", m0_if.waitrequest, 1);
    next();
    s_if.waitrequest = 0;
    for (int b = 3; b <= 4; b++) begin
      exp_gnt.push_back('{m: 0, wr: 1'b1, addr: 32'h3000});
      settle();
      chk("wb_m1_wait_b34", m1_if.waitrequest, 1);
      next();
    end
    m0_if.write = 0;
    exp_gnt.push_back('{m: 1, wr: 1'b1, addr: 32'h4000});
    settle();
    chk("wb_m1_granted", m1_if.waitrequest, 0);
    next();
    m1_if.write = 0;

    // Fill the ownership FIFO with 16 two-beat reads
    for (int i = 0; i < 16; i++) begin
      m0_if.read = 1; m0_if.burstcount = 5'd2; m0_if.address = 32'h5000 + i * 128;
      exp_gnt.push_back('{m: 0, wr: 1'b0, addr: m0_if.address});
      settle();
      next();
    end
    m0_if.address = 32'h6000;
    m1_if.write = 1; m1_if.burstcount = 5'd1; m1_if.address = 32'h7000;
    exp_gnt.push_back('{m: 1, wr: 1'b1, addr: 32'h7000});
    settle();
    chk("full_m0_wait", m0_if.waitrequest, 1);
    chk("full_s_read", s_if.read, 0);
    next();
    m1_if.write = 0;
    settle();
    chk("full_m0_wait2", m0_if.waitrequest, 1);
    next();
    for (int b = 0; b < 2; b++) begin
      s_if.readdatavalid = 1;
      s_if.readdata = {480'd0, 32'hC000_0000 + b};
      exp_rsp.push_back('{m: 0, data: 32'hC000_0000 + b});
      settle();
      chk("full_m0_wait_rsp", m0_if.waitrequest, 1);
      next();
    end
    s_if.readdatavalid = 0;
    exp_gnt.push_back('{m: 0, wr: 1'b0, addr: 32'h6000});
    settle();
    chk("full_release", m0_if.waitrequest, 0);
    next();
    m0_if.read = 0;
    for (int i = 2; i < 34; i++) rsp_beat(0, 32'hC000_0000 + i);

    // Response with empty FIFO: dropped, sticky error
    s_if.readdatavalid = 1;
    s_if.readdata = {480'd0, 32'hBAD0_0001};
    settle();
    chk("unexp_rdv", {m0_if.readdatavalid, m1_if.readdatavalid}, 0);
    next();
    s_if.readdatavalid = 0;
    settle();
    chk("err_set", err, 1);
    repeat (3) next();
    settle();
    chk("err_sticky", err, 1);
    next();

    // Reset mid write burst with reads outstanding
    for (int i = 0; i < 3; i++) begin
      m0_if.read = 1; m0_if.burstcount = 5'd1; m0_if.address = 32'h8000 + i * 64;
      exp_gnt.push_back('{m: 0, wr: 1'b0, addr: m0_if.address});
      settle();
      next();
    end
    m0_if.read = 0;
    m0_if.write = 1; m0_if.burstcount = 5'd8; m0_if.address = 32'h9000;
    exp_gnt.push_back('{m: 0, wr: 1'b1, addr: 32'h9000});
    settle();
    next();
    #1 reset_n = 0;
    #1;
    chk("mid_rst_s_write", s_if.write, 0);
    chk("mid_rst_m0_wait", m0_if.waitrequest, 1);
    chk("mid_rst_m1_wait", m1_if.waitrequest, 1);
    idle_all();
    next();
    next();
    reset_n = 1;
    settle();
    chk("mid_rst_err_clr", err, 0);
    next();
    m1_if.read = 1; m1_if.burstcount = 5'd1; m1_if.address = 32'hA000;
    exp_gnt.push_back('{m: 1, wr: 1'b0, addr: 32'hA000});
    settle();
    next();
    m1_if.read = 0;
    rsp_beat(1, 32'hE000_0001);

    repeat (2) next();
    chk("gnt_queue_drained", exp_gnt.size(), 0);
    chk("rsp_queue_drained", exp_rsp.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
